// File: rtl/round_sequencer.sv
// Round controller for the door-guessing game: countdown, position lock,
// firmware scoring handshake, result pause and game-over handling.
module round_sequencer #(
   parameter int CLK_HZ       = 25_000_000,
   parameter int ROUND_SECS   = 5,
   parameter int PAUSE_CYCLES = 25_000_000,
   parameter int ACK_TIMEOUT  = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] p1_lives,
   input  logic [1:0] p2_lives,
   input  logic       eval_ack,
   output logic [3:0] seconds_left,
   output logic       time_up,
   output logic       resume,
   output logic       pos_latch,
   output logic       eval_req,
   output logic       game_over,
   output logic       ack_timeout,
   output logic [7:0] round_count,
   output logic [2:0] state
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PRE_ONE    = PW'(1);
   localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_CYCLES - 1);
   localparam logic [CW-1:0] PAUSE_ONE  = CW'(1);
   localparam logic [TW-1:0] TO_LAST    = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0] TO_ONE     = TW'(1);
   localparam logic [3:0]    SECS_INIT  = 4'(ROUND_SECS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_LOCK  = 3'd2,
      S_EVAL  = 3'd3,
      S_PAUSE = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [CW-1:0] pcnt_q, pcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [3:0]    secs_q, secs_d;
   logic [7:0]    rnd_q, rnd_d;
   logic          ato_q, ato_d;
   logic          resume_q, resume_d;
   logic          time_up_q, time_up_d;
   logic          latch_q, latch_d;
   logic          req_q, req_d;
   logic          over_q, over_d;

   always_comb begin
      state_d  = state_q;
      pre_d    = pre_q;
      pcnt_d   = pcnt_q;
      tcnt_d   = tcnt_q;
      secs_d   = secs_q;
      rnd_d    = rnd_q;
      ato_d    = ato_q;
      resume_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               secs_d  = SECS_INIT;
               pre_d   = '0;
            end
         end
         S_RUN: begin
            if (pre_q == PRE_LAST) begin
               pre_d  = '0;
               secs_d = secs_q - 4'd1;
               if (secs_q == 4'd1) state_d = S_LOCK;
            end else begin
               pre_d = pre_q + PRE_ONE;
            end
         end
         S_LOCK: begin
            state_d = S_EVAL;
            tcnt_d  = '0;
         end
         S_EVAL: begin
            // A late ack still counts as a clean handshake.
            if (eval_ack) begin
               state_d = S_PAUSE;
               pcnt_d  = '0;
            end else if (tcnt_q == TO_LAST) begin
               state_d = S_PAUSE;
               pcnt_d  = '0;
               ato_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TO_ONE;
            end
         end
         S_PAUSE: begin
            if (pcnt_q == PAUSE_LAST) begin
               pcnt_d = '0;
               if (rnd_q != 8'hFF) rnd_d = rnd_q + 8'd1;
               if (p1_lives == 2'd0 || p2_lives == 2'd0) begin
                  state_d = S_OVER;
               end else begin
                  state_d  = S_RUN;
                  resume_d = 1'b1;
                  secs_d   = SECS_INIT;
                  pre_d    = '0;
               end
            end else begin
               pcnt_d = pcnt_q + PAUSE_ONE;
            end
         end
         S_OVER: begin
            if (start) begin
               state_d = S_RUN;
               rnd_d   = 8'd0;
               ato_d   = 1'b0;
               secs_d  = SECS_INIT;
               pre_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      time_up_d = (state_d == S_LOCK) || (state_d == S_EVAL) ||
                  (state_d == S_PAUSE);
      latch_d   = (state_d == S_LOCK);
      req_d     = (state_d == S_EVAL);
      over_d    = (state_d == S_OVER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pre_q     <= '0;
         pcnt_q    <= '0;
         tcnt_q    <= '0;
         secs_q    <= SECS_INIT;
         rnd_q     <= 8'd0;
         ato_q     <= 1'b0;
         resume_q  <= 1'b0;
         time_up_q <= 1'b0;
         latch_q   <= 1'b0;
         req_q     <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         pcnt_q    <= pcnt_d;
         tcnt_q    <= tcnt_d;
         secs_q    <= secs_d;
         rnd_q     <= rnd_d;
         ato_q     <= ato_d;
         resume_q  <= resume_d;
         time_up_q <= time_up_d;
         latch_q   <= latch_d;
         req_q     <= req_d;
         over_q    <= over_d;
      end
   end

   assign state        = state_q;
   assign seconds_left = secs_q;
   assign round_count  = rnd_q;
   assign ack_timeout  = ato_q;
   assign resume       = resume_q;
   assign time_up      = time_up_q;
   assign pos_latch    = latch_q;
   assign eval_req     = req_q;
   assign game_over    = over_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed scenarios plus random play,
// checked against a phase/elapsed-cycle model of the round rules.
module tb_round_sequencer;

   localparam int CLK_HZ       = 4;
   localparam int ROUND_SECS   = 3;
   localparam int PAUSE_CYCLES = 5;
   localparam int ACK_TIMEOUT  = 8;

   localparam int IDLE  = 0;
   localparam int RUN   = 1;
   localparam int LOCK  = 2;
   localparam int EVAL  = 3;
   localparam int PAUSE = 4;
   localparam int OVER  = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] p1_lives;
   logic [1:0] p2_lives;
   logic       eval_ack;
   logic [3:0] seconds_left;
   logic       time_up;
   logic       resume;
   logic       pos_latch;
   logic       eval_req;
   logic       game_over;
   logic       ack_timeout;
   logic [7:0] round_count;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   int m_phase;
   int m_el;
   int m_rounds;
   bit m_to;
   bit m_res;

   round_sequencer #(
      .CLK_HZ      (CLK_HZ),
      .ROUND_SECS  (ROUND_SECS),
      .PAUSE_CYCLES(PAUSE_CYCLES),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .p1_lives    (p1_lives),
      .p2_lives    (p2_lives),
      .eval_ack    (eval_ack),
      .seconds_left(seconds_left),
      .time_up     (time_up),
      .resume      (resume),
      .pos_latch   (pos_latch),
      .eval_req    (eval_req),
      .game_over   (game_over),
      .ack_timeout (ack_timeout),
      .round_count (round_count),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_secs();
      if (m_phase == IDLE) return ROUND_SECS;
      if (m_phase == RUN) return ROUND_SECS - m_el / CLK_HZ;
      return 0;
   endfunction

   task automatic model_reset();
      m_phase  = IDLE;
      m_el     = 0;
      m_rounds = 0;
      m_to     = 1'b0;
      m_res    = 1'b0;
   endtask

   // Round rules in terms of cycles spent in the current phase.
   task automatic model_step();
      m_res = 1'b0;
      case (m_phase)
         IDLE: if (start) begin m_phase = RUN; m_el = 0; end
         RUN: begin
            m_el++;
            if (m_el == ROUND_SECS * CLK_HZ) begin
               m_phase = LOCK;
               m_el    = 0;
            end
         end
         LOCK: begin m_phase = EVAL; m_el = 0; end
         EVAL: begin
            m_el++;
            if (eval_ack) begin
               m_phase = PAUSE;
               m_el    = 0;
            end else if (m_el == ACK_TIMEOUT) begin
               m_phase = PAUSE;
               m_el    = 0;
               m_to    = 1'b1;
            end
         end
         PAUSE: begin
            m_el++;
            if (m_el == PAUSE_CYCLES) begin
               m_el = 0;
               if (m_rounds < 255) m_rounds++;
               if (p1_lives == 0 || p2_lives == 0) m_phase = OVER;
               else begin
                  m_phase = RUN;
                  m_res   = 1'b1;
               end
            end
         end
         OVER: if (start) begin
            m_phase  = RUN;
            m_el     = 0;
            m_rounds = 0;
            m_to     = 1'b0;
         end
         default: ;
      endcase
   endtask

   task automatic check_all();
      chk("state", state, m_phase);
      chk("seconds_left", seconds_left, exp_secs());
      chk("time_up", time_up,
          m_phase == LOCK || m_phase == EVAL || m_phase == PAUSE);
      chk("pos_latch", pos_latch, m_phase == LOCK);
      chk("eval_req", eval_req, m_phase == EVAL);
      chk("game_over", game_over, m_phase == OVER);
      chk("resume", resume, m_res);
      chk("ack_timeout", ack_timeout, m_to);
      chk("round_count", round_count, m_rounds);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_to(input int target, input int budget);
      int n;
      n = 0;
      while (m_phase != target && n < budget) begin
         tick();
         n++;
      end
      chk("reach_phase", state, target);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      model_reset();
      check_all();
      chk("rst_eval_req", eval_req, 0);
      chk("rst_secs", seconds_left, ROUND_SECS);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      eval_ack = 1'b0;
      p1_lives = 2'd3;
      p2_lives = 2'd3;
      model_reset();
      #12;
      check_all();
      chk("reset_state", state, IDLE);
      chk("reset_secs", seconds_left, 3);
      reset = 1'b0;

      // First round: countdown 3,2,1,0 then LOCK.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run_cycle1", state, RUN);
      tick_n(4);
      chk("secs_2", seconds_left, 2);
      tick_n(4);
      chk("secs_1", seconds_left, 1);
      tick_n(3);
      chk("still_run", state, RUN);
      tick();
      chk("lock", state, LOCK);
      chk("lock_latch", pos_latch, 1);
      chk("lock_time_up", time_up, 1);
      chk("lock_secs", seconds_left, 0);
      tick();
      chk("eval", state, EVAL);
      chk("latch_gone", pos_latch, 0);

      // Ack on the 3rd EVAL cycle.
      tick_n(2);
      eval_ack = 1'b1;
      tick();
      eval_ack = 1'b0;
      chk("pause_after_ack", state, PAUSE);
      tick_n(4);
      chk("resume_wait", resume, 0);
      tick();
      chk("resume_pulse", resume, 1);
      chk("round1", round_count, 1);
      chk("round1_secs", seconds_left, 3);
      tick();
      chk("resume_once", resume, 0);

      // Ignored start/ack in RUN, then timeout.
      start    = 1'b1;
      eval_ack = 1'b1;
      tick_n(3);
      start    = 1'b0;
      eval_ack = 1'b0;
      chk("run_ignores", state, RUN);
      run_to(EVAL, 20);
      tick_n(7);
      chk("eval_7", state, EVAL);
      tick();
      chk("timeout_pause", state, PAUSE);
      chk("timeout_flag", ack_timeout, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("pause_ignores", state, PAUSE);
      run_to(RUN, 10);
      chk("sticky_run", ack_timeout, 1);

      // Round 3: ack, lose a life, game over.
      run_to(EVAL, 20);
      eval_ack = 1'b1;
      tick();
      eval_ack = 1'b0;
      p2_lives = 2'd0;
      tick_n(4);
      chk("no_over_yet", state, PAUSE);
      tick();
      chk("gameover", game_over, 1);
      chk("gameover_resume", resume, 0);
      chk("gameover_rounds", round_count, 3);
      chk("gameover_sticky", ack_timeout, 1);
      p2_lives = 2'd3;
      tick_n(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_state", state, RUN);
      chk("restart_rounds", round_count, 0);
      chk("restart_flag", ack_timeout, 0);

      // Ack coincident with timeout expiry.
      run_to(EVAL, 20);
      tick_n(7);
      eval_ack = 1'b1;
      tick();
      eval_ack = 1'b0;
      chk("coinc_pause", state, PAUSE);
      chk("coinc_flag", ack_timeout, 0);

      // Reset mid-RUN and mid-EVAL.
      run_to(RUN, 10);
      tick_n(5);
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to(EVAL, 20);
      tick_n(2);
      do_reset();
      tick_n(3);

      // Random play including lost lives.
      for (int i = 0; i < 1500; i++) begin
         start    = ($urandom_range(0, 15) == 0);
         eval_ack = ($urandom_range(0, 5) == 0);
         p1_lives = ($urandom_range(0, 30) == 0) ? 2'd0
                    : 2'($urandom_range(1, 3));
         p2_lives = ($urandom_range(0, 30) == 0) ? 2'd0
                    : 2'($urandom_range(1, 3));
         tick();
      end

      // Long game with no losses to saturate round_count.
      for (int i = 0; i < 9000; i++) begin
         start    = ($urandom_range(0, 15) == 0);
         eval_ack = ($urandom_range(0, 4) == 0);
         p1_lives = 2'($urandom_range(1, 3));
         p2_lives = 2'($urandom_range(1, 3));
         tick();
      end
      chk("round_saturate", round_count, 255);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
